// File: rtl/cc_stat_if.sv
// cc_stat_if: point stream in, summary words out.
// Handshake: there is no backpressure. in_valid qualifies xi/yi on every
// rising clk edge where it is high. out_valid qualifies xo/yo the same way,
// and xo/yo are forced to zero whenever out_valid is low.
interface cc_stat_if;
    logic       in_valid;
    logic [7:0] xi;
    logic [7:0] yi;
    logic       out_valid;
    logic [7:0] xo;
    logic [7:0] yo;

    modport master (
        output in_valid, xi, yi,
        input  out_valid, xo, yo
    );

    modport slave (
        input  in_valid, xi, yi,
        output out_valid, xo, yo
    );
endinterface

// File: rtl/cc_stat.sv
// cc_stat: collects bounding box, point count and (optionally) row count
// over a burst of signed (x, y) points, then emits the summary as a short
// train of words.
// Optional feature: define CC_STAT_ROWCNT_EN to add the 9-bit rows counter
// and the fourth summary word. Without it the summary is three words long.
module cc_stat (
    input  logic       clk,
    input  logic       rst_n,
    cc_stat_if.slave   bus,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACC      = 2'd1,
        OUT      = 2'd2,
        WAIT_LOW = 2'd3
    } state_t;

    state_t            state;
    logic        [2:0] widx;       // index of the next summary word to load
    logic signed [7:0] min_x;
    logic signed [7:0] max_x;
    logic signed [7:0] min_y;
    logic signed [7:0] max_y;
    logic       [15:0] count;
`ifdef CC_STAT_ROWCNT_EN
    logic        [8:0] rows;
    logic        [7:0] prev_y;     // y of the previous accepted point
`endif

    assign state_dbg = state;

    // Single FSM: accumulate the burst, stream out the summary, then wait for
    // the upstream valid to drop before rearming.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            widx          <= 3'd0;
            bus.out_valid <= 1'b0;
            bus.xo        <= 8'd0;
            bus.yo        <= 8'd0;
            min_x         <= 8'sd0;
            max_x         <= 8'sd0;
            min_y         <= 8'sd0;
            max_y         <= 8'sd0;
            count         <= 16'd0;
`ifdef CC_STAT_ROWCNT_EN
            rows          <= 9'd0;
            prev_y        <= 8'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    bus.out_valid <= 1'b0;
                    bus.xo        <= 8'd0;
                    bus.yo        <= 8'd0;
                    if (bus.in_valid) begin
                        min_x <= $signed(bus.xi);
                        max_x <= $signed(bus.xi);
                        min_y <= $signed(bus.yi);
                        max_y <= $signed(bus.yi);
                        count <= 16'd1;
`ifdef CC_STAT_ROWCNT_EN
                        rows   <= 9'd1;
                        prev_y <= bus.yi;
`endif
                        state <= ACC;
                    end
                end

                ACC: begin
                    if (bus.in_valid) begin
                        if ($signed(bus.xi) < min_x) min_x <= $signed(bus.xi);
                        if ($signed(bus.xi) > max_x) max_x <= $signed(bus.xi);
                        if ($signed(bus.yi) < min_y) min_y <= $signed(bus.yi);
                        if ($signed(bus.yi) > max_y) max_y <= $signed(bus.yi);
                        if (count != 16'hFFFF) count <= count + 16'd1;
`ifdef CC_STAT_ROWCNT_EN
                        if ((bus.yi != prev_y) && (rows != 9'h1FF)) rows <= rows + 9'd1;
                        prev_y <= bus.yi;
`endif
                    end else begin
                        // First word leaves on the same edge the burst ends.
                        bus.out_valid <= 1'b1;
                        bus.xo        <= min_x;
                        bus.yo        <= min_y;
                        widx          <= 3'd1;
                        state         <= OUT;
                    end
                end

                OUT: begin
                    widx <= widx + 3'd1;
                    case (widx)
                        3'd1: begin
                            bus.xo <= max_x;
                            bus.yo <= max_y;
                        end
                        3'd2: begin
                            bus.xo <= count[15:8];
                            bus.yo <= count[7:0];
                        end
`ifdef CC_STAT_ROWCNT_EN
                        3'd3: begin
                            bus.xo <= {7'd0, rows[8]};
                            bus.yo <= rows[7:0];
                        end
`endif
                        default: begin
                            // Last word has been shown; a burst that started
                            // during the summary is dropped via WAIT_LOW.
                            bus.out_valid <= 1'b0;
                            bus.xo        <= 8'd0;
                            bus.yo        <= 8'd0;
                            state         <= bus.in_valid ? WAIT_LOW : IDLE;
                        end
                    endcase
                end

                WAIT_LOW: begin
                    bus.out_valid <= 1'b0;
                    bus.xo        <= 8'd0;
                    bus.yo        <= 8'd0;
                    if (!bus.in_valid) state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cc_stat.sv
// tb_cc_stat: randomized and directed bursts against a behavioural summary
// model; a negedge monitor checks every output cycle against the queue of
// expected summary words.
module tb_cc_stat;

`ifdef CC_STAT_ROWCNT_EN
    localparam int NW = 4;
`else
    localparam int NW = 3;
`endif

    logic       clk;
    logic       rst_n;
    logic [1:0] state_dbg;

    cc_stat_if bus();

    cc_stat dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #950000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard state ----------------
    int          n_checks;
    int          n_fail;
    int          reset_epoch;
    logic [15:0] exp_q[$];
    logic [7:0]  bx_q[$];
    logic [7:0]  by_q[$];
    logic [15:0] mw[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Summary of the points in bx_q/by_q, computed straight from the rules.
    task automatic model_compute();
        int mnx, mxx, mny, mxy, sx, sy, cnt, rows;
        mnx = 127; mxx = -128; mny = 127; mxy = -128;
        rows = 1;
        for (int i = 0; i < bx_q.size(); i++) begin
            sx = $signed(bx_q[i]);
            sy = $signed(by_q[i]);
            if (sx < mnx) mnx = sx;
            if (sx > mxx) mxx = sx;
            if (sy < mny) mny = sy;
            if (sy > mxy) mxy = sy;
            if (i > 0 && by_q[i] != by_q[i-1]) rows++;
        end
        cnt = (bx_q.size() > 65535) ? 65535 : bx_q.size();
        if (rows > 511) rows = 511;
        mw[0] = {8'(mnx), 8'(mny)};
        mw[1] = {8'(mxx), 8'(mxy)};
        mw[2] = 16'(cnt);
        mw[3] = {7'd0, rows[8], rows[7:0]};
    endtask

    // ---------------- driver tasks ----------------
    // Drives the points in bx_q/by_q as one burst, expects its summary, and
    // returns at the negedge where the first word must be visible.
    task automatic run_burst();
        model_compute();
        for (int i = 0; i < NW; i++) exp_q.push_back(mw[i]);
        for (int i = 0; i < bx_q.size(); i++) begin
            @(posedge clk); #1;
            bus.in_valid = 1'b1;
            bus.xi       = bx_q[i];
            bus.yi       = by_q[i];
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.xi       = 8'd0;
        bus.yi       = 8'd0;
        @(posedge clk);
        @(negedge clk);
        check("first_word_latency", 32'(bus.out_valid), 32'd1);
    endtask

    task automatic wait_summary_done(input int gap);
        repeat (NW - 1 + gap) @(posedge clk);
    endtask

    task automatic random_points(input int len, input bit few_rows);
        bx_q.delete();
        by_q.delete();
        for (int i = 0; i < len; i++) begin
            bx_q.push_back(8'($urandom_range(0, 255)));
            by_q.push_back(few_rows ? 8'($urandom_range(0, 2)) : 8'($urandom_range(0, 255)));
        end
    endtask

    // ---------------- compare process ----------------
    initial begin
        int          run_len;
        int          seen_epoch;
        logic [15:0] w;
        run_len    = 0;
        seen_epoch = 0;
        forever begin
            @(negedge clk);
            if (seen_epoch != reset_epoch) begin
                run_len    = 0;
                seen_epoch = reset_epoch;
            end
            if (rst_n) begin
                if (bus.out_valid) begin
                    run_len++;
                    check("word_expected", 32'(exp_q.size() > 0), 32'd1);
                    if (exp_q.size() > 0) begin
                        w = exp_q.pop_front();
                        check("summary_word", {16'd0, bus.xo, bus.yo}, {16'd0, w});
                    end
                end else begin
                    check("idle_outputs_zero", {16'd0, bus.xo, bus.yo}, 32'd0);
                    if (run_len > 0) begin
                        check("summary_length", 32'(run_len), 32'(NW));
                        run_len = 0;
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        n_checks     = 0;
        n_fail       = 0;
        reset_epoch  = 0;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.xi       = 8'd0;
        bus.yi       = 8'd0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_xo_yo", {16'd0, bus.xo, bus.yo}, 32'd0);
        check("reset_state_idle", 32'(state_dbg), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // trapezoid row
        bx_q = {8'd2, 8'd3, 8'd4};
        by_q = {8'd5, 8'd5, 8'd5};
        model_compute();
        check("pin_trap_w0", 32'(mw[0]), 32'h0205);
        check("pin_trap_w1", 32'(mw[1]), 32'h0405);
        check("pin_trap_w2", 32'(mw[2]), 32'h0003);
        check("pin_trap_w3", 32'(mw[3]), 32'h0001);
        run_burst();
        wait_summary_done(0);

        // signed extremes, back-to-back with the previous summary
        bx_q = {8'h80, 8'h7F, 8'h00};
        by_q = {8'h7F, 8'h80, 8'h00};
        model_compute();
        check("pin_ext_w0", 32'(mw[0]), 32'h8080);
        check("pin_ext_w1", 32'(mw[1]), 32'h7F7F);
        check("pin_ext_w2", 32'(mw[2]), 32'h0003);
        run_burst();
        wait_summary_done(1);

        // single point
        bx_q = {8'hFF};
        by_q = {8'hFF};
        model_compute();
        check("pin_single_w0", 32'(mw[0]), 32'hFFFF);
        check("pin_single_w1", 32'(mw[1]), 32'hFFFF);
        check("pin_single_w2", 32'(mw[2]), 32'h0001);
        check("pin_single_w3", 32'(mw[3]), 32'h0001);
        run_burst();
        wait_summary_done(2);

        // overlap: a burst raised during W1 must be discarded whole
        random_points(5, 1'b0);
        run_burst();
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) begin
            bus.in_valid = 1'b1;
            bus.xi       = 8'($urandom_range(0, 255));
            bus.yi       = 8'($urandom_range(0, 255));
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        bus.xi       = 8'd0;
        bus.yi       = 8'd0;
        repeat (3) @(posedge clk);
        bx_q = {8'd1};
        by_q = {8'd1};
        model_compute();
        check("pin_clean_w0", 32'(mw[0]), 32'h0101);
        check("pin_clean_w2", 32'(mw[2]), 32'h0001);
        run_burst();
        wait_summary_done(2);

        // reset during W1
        random_points(4, 1'b1);
        run_burst();
        @(posedge clk); #2;
        rst_n = 1'b0;
        reset_epoch++;
        exp_q.delete();
        #1;
        check("rst_mid_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_mid_out_xo_yo", {16'd0, bus.xo, bus.yo}, 32'd0);
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (8) @(posedge clk);

        // reset in the middle of a burst: nothing may come out afterwards
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            bus.in_valid = 1'b1;
            bus.xi       = 8'($urandom_range(0, 255));
            bus.yi       = 8'($urandom_range(0, 255));
        end
        @(posedge clk); #2;
        rst_n        = 1'b0;
        reset_epoch++;
        bus.in_valid = 1'b0;
        #1;
        check("rst_mid_burst_valid", 32'(bus.out_valid), 32'd0);
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (8) @(posedge clk);

        // randomized bursts
        for (int b = 0; b < 30; b++) begin
            random_points($urandom_range(1, 12), 1'($urandom_range(0, 1)));
            run_burst();
            wait_summary_done($urandom_range(0, 3));
        end

        // saturation: 70000 points, y toggling every cycle
        bx_q.delete();
        by_q.delete();
        for (int i = 0; i < 70000; i++) begin
            bx_q.push_back(8'($urandom_range(0, 255)));
            by_q.push_back((i % 2 == 0) ? 8'h10 : 8'h11);
        end
        model_compute();
        check("pin_sat_w2", 32'(mw[2]), 32'hFFFF);
        check("pin_sat_w3", 32'(mw[3]), 32'h01FF);
        run_burst();
        wait_summary_done(4);

        repeat (6) @(posedge clk);
        check("all_words_seen", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
